fetch_pc_unit: RTL and testbench

- Front end of the RV32I core: owns the architectural fetch PC and issues sequential instruction-memory reads.
- Buffers returned instructions and presents them with their PC to decode/execute.
- Consumes the redirect target produced by the execution-unit branch logic.
- Forms the producer side of the pc/new_pc loop: its pc_o drives the branch unit's PC input, and the branch unit's target returns on new_pc_i.

---
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 tb/tb_fetch_pc_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// RV32I fetch front end: owns the fetch PC, issues single-outstanding imem reads,
// and buffers returned instructions with their PC for decode/execute.
module fetch_pc_unit #(
   parameter int unsigned              DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0,
   parameter int unsigned              BUF_DEPTH  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] new_pc_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   input  logic                  instr_ready_i
);

   localparam int unsigned     PW      = $clog2(BUF_DEPTH);
   localparam int unsigned     CW      = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t                r_state, w_state_next;
   logic [DATA_WIDTH-1:0] r_fetch_pc, r_req_pc;
   logic                  r_discard;
   logic [DATA_WIDTH-1:0] r_buf_pc    [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] r_buf_instr [BUF_DEPTH];
   logic [PW-1:0]         r_wptr, r_rptr;
   logic [CW-1:0]         r_count, w_count_next;
   logic                  w_gnt_fire, w_rvalid_fire, w_push, w_pop, w_space_next;
   logic                  w_discard_on_redirect;

   assign imem_req_o    = (r_state == S_REQ);
   assign imem_addr_o   = r_fetch_pc;
   assign instr_valid_o = (r_count != '0);
   assign instr_o       = r_buf_instr[r_rptr];
   assign pc_o          = r_buf_pc[r_rptr];

   always_comb begin
      w_gnt_fire    = (r_state == S_REQ) && imem_gnt_i;
      w_rvalid_fire = (r_state == S_WAIT) && imem_rvalid_i;
      w_push        = w_rvalid_fire && !r_discard && !redirect_i;
      w_pop         = instr_valid_o && instr_ready_i && !redirect_i;
      w_count_next  = redirect_i ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      w_space_next  = (w_count_next < DEPTH_C);
      // A redirect leaves a request in flight only if it was granted now or is still pending.
      w_discard_on_redirect = w_gnt_fire || ((r_state == S_WAIT) && !imem_rvalid_i);
   end

   always_comb begin
      w_state_next = r_state;
      if (redirect_i) begin
         w_state_next = w_discard_on_redirect ? S_WAIT : S_REQ;
      end else begin
         case (r_state)
            S_IDLE:  if (w_space_next) w_state_next = S_REQ;
            S_REQ:   if (imem_gnt_i) w_state_next = S_WAIT;
            S_WAIT:  if (imem_rvalid_i) w_state_next = w_space_next ? S_REQ : S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_discard  <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            r_buf_pc[i]    <= '0;
            r_buf_instr[i] <= '0;
         end
      end else begin
         r_count <= w_count_next;
         if (w_gnt_fire) r_req_pc <= r_fetch_pc;
         if (redirect_i) begin
            r_fetch_pc <= {new_pc_i[DATA_WIDTH-1:2], 2'b00};
            r_discard  <= w_discard_on_redirect;
            r_wptr     <= '0;
            r_rptr     <= '0;
         end else begin
            if (w_gnt_fire)    r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
            if (w_rvalid_fire) r_discard  <= 1'b0;
            if (w_push) begin
               r_buf_pc[r_wptr]    <= r_req_pc;
               r_buf_instr[r_wptr] <= imem_rdata_i;
               r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: cycle-by-cycle stimulus with hand-computed
// request/address/head expectations after every clock.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_i, redirect_i, imem_gnt_i, imem_rvalid_i, instr_ready_i;
   logic [31:0] new_pc_i, imem_rdata_i;
   logic        imem_req_o, instr_valid_o;
   logic [31:0] imem_addr_o, instr_o, pc_o;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .new_pc_i(new_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
      .instr_ready_i(instr_ready_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Head pc/instr are only meaningful while valid, so they are checked only then.
   task automatic expect_o(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, ".req"}, {31'b0, imem_req_o}, {31'b0, req});
      check({tag, ".addr"}, imem_addr_o, addr);
      check({tag, ".valid"}, {31'b0, instr_valid_o}, {31'b0, valid});
      if (valid) begin
         check({tag, ".pc"}, pc_o, pc);
         check({tag, ".instr"}, instr_o, ins);
      end
   endtask

   task automatic cyc(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic rdr, input logic [31:0] np);
      imem_gnt_i    = g;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      instr_ready_i = rdy;
      redirect_i    = rdr;
      new_pc_i      = np;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      redirect_i = 1'b0; new_pc_i = '0; imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst.req", {31'b0, imem_req_o}, 32'd0);
      check("rst.addr", imem_addr_o, 32'h0);
      check("rst.valid", {31'b0, instr_valid_o}, 32'd0);
      check("rst.instr", instr_o, 32'h0);
      check("rst.pc", pc_o, 32'h0);
      rst_i = 1'b0;
   endtask

   initial begin
      // A: streaming with ready=1, gnt high, rvalid one cycle after gnt
      do_reset();
      check("a0.req", {31'b0, imem_req_o}, 32'd0);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("a1", 1, 32'h0, 0, 0, 0);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("a2", 0, 32'h4, 0, 0, 0);
      cyc(1, 1, 32'h1111_0000, 1, 0, 32'h0);     expect_o("a3", 1, 32'h4, 1, 32'h0, 32'h1111_0000);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("a4", 0, 32'h8, 0, 0, 0);
      cyc(1, 1, 32'h1111_0004, 1, 0, 32'h0);     expect_o("a5", 1, 32'h8, 1, 32'h4, 32'h1111_0004);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("a6", 0, 32'hC, 0, 0, 0);
      cyc(1, 1, 32'h1111_0008, 1, 0, 32'h0);     expect_o("a7", 1, 32'hC, 1, 32'h8, 32'h1111_0008);

      // B: ready held low fills exactly two entries, then drains in order
      do_reset();
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b1", 1, 32'h0, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b2", 0, 32'h4, 0, 0, 0);
      cyc(1, 1, 32'h2222_0000, 0, 0, 32'h0);     expect_o("b3", 1, 32'h4, 1, 32'h0, 32'h2222_0000);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b4", 0, 32'h8, 1, 32'h0, 32'h2222_0000);
      cyc(1, 1, 32'h2222_0004, 0, 0, 32'h0);     expect_o("b5", 0, 32'h8, 1, 32'h0, 32'h2222_0000);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b6", 0, 32'h8, 1, 32'h0, 32'h2222_0000);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b7", 0, 32'h8, 1, 32'h0, 32'h2222_0000);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("b8", 1, 32'h8, 1, 32'h4, 32'h2222_0004);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("b9", 0, 32'hC, 1, 32'h4, 32'h2222_0004);

      // C: redirect in WAIT with one entry buffered; pending rdata dropped
      cyc(1, 0, 32'h0, 0, 1, 32'h0000_0103);     expect_o("c1", 0, 32'h100, 0, 0, 0);
      cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);     expect_o("c2", 1, 32'h100, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("c3", 0, 32'h104, 0, 0, 0);
      cyc(1, 1, 32'h3333_0100, 0, 0, 32'h0);     expect_o("c4", 1, 32'h104, 1, 32'h100, 32'h3333_0100);

      // D: redirect in the same cycle as rvalid
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("d1", 0, 32'h108, 1, 32'h100, 32'h3333_0100);
      cyc(1, 1, 32'hBAD0_0104, 0, 1, 32'h200);   expect_o("d2", 1, 32'h200, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("d3", 0, 32'h204, 0, 0, 0);
      cyc(1, 1, 32'h4444_0200, 0, 0, 32'h0);     expect_o("d4", 1, 32'h204, 1, 32'h200, 32'h4444_0200);

      // E: redirect in REQ without gnt (pop ignored), PC wrap, redirect with gnt, back-to-back redirects
      cyc(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);     expect_o("e1", 1, 32'hFFFF_FFFC, 0, 0, 0);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("e2", 0, 32'h0, 0, 0, 0);
      cyc(1, 1, 32'h5555_FFFC, 0, 0, 32'h0);     expect_o("e3", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h5555_FFFC);
      cyc(1, 0, 32'h0, 1, 1, 32'h300);           expect_o("e4", 0, 32'h300, 0, 0, 0);
      cyc(1, 1, 32'hBAD1_0000, 1, 0, 32'h0);     expect_o("e5", 1, 32'h300, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, 1, 32'h400);           expect_o("e6", 1, 32'h400, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, 1, 32'h504);           expect_o("e7", 1, 32'h504, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("e8", 0, 32'h508, 0, 0, 0);
      cyc(1, 1, 32'h6666_0504, 0, 0, 32'h0);     expect_o("e9", 1, 32'h508, 1, 32'h504, 32'h6666_0504);

      // F: asynchronous reset while in WAIT with an entry buffered, stray rvalid ignored
      cyc(1, 0, 32'h0, 0, 0, 32'h0);             expect_o("f1", 0, 32'h50C, 1, 32'h504, 32'h6666_0504);
      rst_i = 1'b1;
      #1;
      check("f2.valid", {31'b0, instr_valid_o}, 32'd0);
      check("f2.req", {31'b0, imem_req_o}, 32'd0);
      check("f2.addr", imem_addr_o, 32'h0);
      check("f2.pc", pc_o, 32'h0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD2_0000;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      cyc(1, 1, 32'hBAD3_0000, 1, 0, 32'h0);     expect_o("f3", 1, 32'h0, 0, 0, 0);
      cyc(1, 0, 32'h0, 1, 0, 32'h0);             expect_o("f4", 0, 32'h4, 0, 0, 0);
      cyc(1, 1, 32'h7777_0000, 1, 0, 32'h0);     expect_o("f5", 1, 32'h4, 1, 32'h0, 32'h7777_0000);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
